ui_arrow_anim: RTL and testbench

Parametrised arrow animator for the 160x120 VGA UI layer. On a start pulse it draws one arrow pointing up, down, left or right: a straight shaft, then a two-armed head. It emits one pixel per paced step on the vga_adapter `x`/`y`/`colour`/`plot` bus and signals completion with a one-cycle `done`. It generalises the fixed up-arrow drawer with selectable direction, sizes, origin, pacing and per-draw colour, plus an optional self-erase pass.

---
 rtl/ui_anim_pkg.sv | 52 +++++
 rtl/ui_step_timer.sv | 26 ++
 rtl/ui_arrow_anim.sv | 229 ++++++++++++++++++++++
 tb/tb_ui_arrow_anim.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ui_anim_pkg.sv
// Shared types and helpers for the VGA UI animators: direction codes, the arrow
// FSM state type and the direction / head-arm unit vectors.
package ui_anim_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHAFT,
        S_HEAD,
        S_HOLD,
        S_DONE
`ifdef UI_ARROW_ERASE_EN
        , S_ERASE
`endif
    } anim_state_e;

    // Unit step on each axis, each component in {-1, 0, +1}.
    typedef struct packed {
        logic signed [1:0] dx;
        logic signed [1:0] dy;
    } vec2_t;

    // Screen y grows downward, so "up" is a negative y step.
    function automatic vec2_t dir_vec(input logic [1:0] dir);
        vec2_t v;
        v = '0;
        case (dir)
            DIR_UP:   v.dy = -2'sd1;
            DIR_DOWN: v.dy = 2'sd1;
            DIR_LEFT: v.dx = -2'sd1;
            default:  v.dx = 2'sd1;
        endcase
        return v;
    endfunction

    // Arm A steps along this vector, arm B along its negation.
    function automatic vec2_t arm_offset(input logic [1:0] dir);
        vec2_t v;
        v = '0;
        if (dir == DIR_UP || dir == DIR_DOWN) begin
            v.dx = -2'sd1;
        end else begin
            v.dy = -2'sd1;
        end
        return v;
    endfunction

endpackage

// File: rtl/ui_step_timer.sv
// Step prescaler for UI animators: counts 0..STEP_DIV-1 while enabled and
// flags a tick on the terminal count; clr restarts the count from zero.
module ui_step_timer #(
    parameter int STEP_DIV = 3125000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick_c
);
    localparam int unsigned CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    logic [CNT_W-1:0] cnt_q;

    assign tick_c = en && !clr && (cnt_q == CNT_W'(STEP_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ui_arrow_anim.sv
// Paced arrow drawer for the 160x120 VGA UI layer: shaft, then two-armed head.
// Define UI_ARROW_ERASE_EN to add a replay pass that erases in BG_COLOUR.
module ui_arrow_anim
    import ui_anim_pkg::*;
#(
    parameter int X_W        = 8,
    parameter int Y_W        = 7,
    parameter int COLOUR_W   = 3,
    parameter int ORIGIN_X   = 79,
    parameter int ORIGIN_Y   = 63,
    parameter int SHAFT_LEN  = 8,
    parameter int HEAD_LEN   = 4,
    parameter int STEP_DIV   = 3125000,
    parameter int HOLD_STEPS = 2,
    parameter int X_MAX      = 159,
    parameter int Y_MAX      = 119,
    parameter int BG_COLOUR  = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          dir,
    input  logic [COLOUR_W-1:0] colour,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour_out,
    output logic                plot,
    output logic                busy,
    output logic                done
);
    localparam int unsigned XS     = X_W + 1;
    localparam int unsigned YS     = Y_W + 1;
    localparam int unsigned P      = SHAFT_LEN + 2 * HEAD_LEN;
    localparam int unsigned PIX_W  = $clog2(P + 1);
    localparam int unsigned HOLD_W = (HOLD_STEPS > 0) ? $clog2(HOLD_STEPS + 1) : 1;

    anim_state_e         state_q, state_d;
    logic [PIX_W-1:0]    pix_q, pix_d, k_c, j_c, h_c;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [1:0]          dir_q, dir_d;
    logic [COLOUR_W-1:0] col_q, col_d, cout_d, emit_col_c;
    logic [X_W-1:0]      x_d;
    logic [Y_W-1:0]      y_d;
    logic                plot_d, busy_d, done_d;
    logic                emit_c, arm_b_c, vis_c, erasing_c;
    logic                tmr_clr_c, tmr_en_c, tick_c;
    vec2_t               d_c, a_c;
    logic signed [XS-1:0] px_c;
    logic signed [YS-1:0] py_c;

    function automatic logic signed [XS-1:0] sx(input logic signed [1:0] u,
                                                input logic [PIX_W-1:0] n);
        logic signed [XS-1:0] m;
        m = $signed(XS'(n));
        case (u)
            2'sb01:  return m;
            2'sb11:  return -m;
            default: return '0;
        endcase
    endfunction

    function automatic logic signed [YS-1:0] sy(input logic signed [1:0] u,
                                                input logic [PIX_W-1:0] n);
        logic signed [YS-1:0] m;
        m = $signed(YS'(n));
        case (u)
            2'sb01:  return m;
            2'sb11:  return -m;
            default: return '0;
        endcase
    endfunction

    assign tmr_en_c = (state_q != S_IDLE);

    ui_step_timer #(
        .STEP_DIV(STEP_DIV)
    ) u_step_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (tmr_clr_c || (state_q == S_IDLE)),
        .en     (tmr_en_c),
        .tick_c (tick_c)
    );

    // Pixel index -> coordinate: shaft pixel k, or head arm j (A on even, B on odd).
    always_comb begin
        d_c = dir_vec(dir_q);
        a_c = arm_offset(dir_q);
        h_c = pix_q - PIX_W'(SHAFT_LEN);
        if (pix_q < PIX_W'(SHAFT_LEN)) begin
            k_c     = pix_q;
            j_c     = '0;
            arm_b_c = 1'b0;
        end else begin
            k_c     = PIX_W'(SHAFT_LEN - 1);
            j_c     = (h_c >> 1) + PIX_W'(1);
            arm_b_c = h_c[0];
        end
        px_c = XS'(ORIGIN_X) + sx(d_c.dx, k_c) - sx(d_c.dx, j_c)
             + (arm_b_c ? -sx(a_c.dx, j_c) : sx(a_c.dx, j_c));
        py_c = YS'(ORIGIN_Y) + sy(d_c.dy, k_c) - sy(d_c.dy, j_c)
             + (arm_b_c ? -sy(a_c.dy, j_c) : sy(a_c.dy, j_c));
        vis_c = !px_c[XS-1] && (px_c <= $signed(XS'(X_MAX)))
             && !py_c[YS-1] && (py_c <= $signed(YS'(Y_MAX)));
    end

`ifdef UI_ARROW_ERASE_EN
    assign erasing_c = (state_q == S_ERASE);
`else
    assign erasing_c = 1'b0;
`endif
    assign emit_col_c = erasing_c ? COLOUR_W'(BG_COLOUR) : col_q;

    always_comb begin
        state_d   = state_q;
        pix_d     = pix_q;
        hold_d    = hold_q;
        dir_d     = dir_q;
        col_d     = col_q;
        x_d       = x;
        y_d       = y;
        cout_d    = colour_out;
        plot_d    = 1'b0;
        busy_d    = 1'b1;
        done_d    = 1'b0;
        emit_c    = 1'b0;
        tmr_clr_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d = S_SHAFT;
                    dir_d   = dir;
                    col_d   = colour;
                    pix_d   = '0;
                    hold_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            S_SHAFT: begin
                if (tick_c) begin
                    emit_c = 1'b1;
                    pix_d  = pix_q + PIX_W'(1);
                    if (pix_q == PIX_W'(SHAFT_LEN - 1)) state_d = S_HEAD;
                end
            end
            S_HEAD: begin
                if (tick_c) begin
                    emit_c = 1'b1;
                    if (pix_q == PIX_W'(P - 1)) begin
                        pix_d   = '0;
                        state_d = S_HOLD;
                    end else begin
                        pix_d = pix_q + PIX_W'(1);
                    end
                end
            end
            S_HOLD: begin
                if (hold_q == HOLD_W'(HOLD_STEPS)) begin
`ifdef UI_ARROW_ERASE_EN
                    // Restart pacing so the replay matches the draw timing.
                    state_d   = S_ERASE;
                    tmr_clr_c = 1'b1;
`else
                    state_d = S_DONE;
                    done_d  = 1'b1;
`endif
                end else if (tick_c) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
`ifdef UI_ARROW_ERASE_EN
            S_ERASE: begin
                if (tick_c) begin
                    emit_c = 1'b1;
                    if (pix_q == PIX_W'(P - 1)) begin
                        pix_d   = '0;
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        pix_d = pix_q + PIX_W'(1);
                    end
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
        // Clipped pixels consume their step but leave the bus untouched.
        if (emit_c && vis_c) begin
            x_d    = px_c[X_W-1:0];
            y_d    = py_c[Y_W-1:0];
            cout_d = emit_col_c;
            plot_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pix_q      <= '0;
            hold_q     <= '0;
            dir_q      <= DIR_UP;
            col_q      <= '0;
            x          <= X_W'(ORIGIN_X);
            y          <= Y_W'(ORIGIN_Y);
            colour_out <= '0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            pix_q      <= pix_d;
            hold_q     <= hold_d;
            dir_q      <= dir_d;
            col_q      <= col_d;
            x          <= x_d;
            y          <= y_d;
            colour_out <= cout_d;
            plot       <= plot_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

endmodule

// File: tb/tb_ui_arrow_anim.sv
// Bench for ui_arrow_anim: two instances (paced / unpaced with edge clipping)
// checked cycle by cycle against an arithmetic model of the arrow geometry.
module tb_ui_arrow_anim;

    localparam int SD_A = 2, H_A = 1, OXA = 10,  OYA = 20;
    localparam int SD_B = 1, H_B = 0, OXB = 157, OYB = 1;
    localparam int SHAFT = 4, HEAD = 2, P = SHAFT + 2 * HEAD;
    localparam int XMAX = 159, YMAX = 119;
`ifdef UI_ARROW_ERASE_EN
    localparam bit ERASE = 1'b1;
`else
    localparam bit ERASE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic [1:0] dir = 2'd0;
    logic [2:0] colour = 3'd0;
    logic [7:0] xa, xb;
    logic [6:0] ya, yb;
    logic [2:0] ca, cb;
    logic       plota, plotb, busya, busyb, donea, doneb;

    int n_cmp = 0;
    int n_fail = 0;
    int ex[2];
    int ey[2];
    int ec[2];

    always #5 clk = ~clk;

    ui_arrow_anim #(
        .X_W(8), .Y_W(7), .COLOUR_W(3), .ORIGIN_X(OXA), .ORIGIN_Y(OYA),
        .SHAFT_LEN(SHAFT), .HEAD_LEN(HEAD), .STEP_DIV(SD_A), .HOLD_STEPS(H_A),
        .X_MAX(XMAX), .Y_MAX(YMAX), .BG_COLOUR(0)
    ) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .dir(dir), .colour(colour),
        .x(xa), .y(ya), .colour_out(ca), .plot(plota), .busy(busya), .done(donea)
    );

    ui_arrow_anim #(
        .X_W(8), .Y_W(7), .COLOUR_W(3), .ORIGIN_X(OXB), .ORIGIN_Y(OYB),
        .SHAFT_LEN(SHAFT), .HEAD_LEN(HEAD), .STEP_DIV(SD_B), .HOLD_STEPS(H_B),
        .X_MAX(XMAX), .Y_MAX(YMAX), .BG_COLOUR(0)
    ) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .dir(dir), .colour(colour),
        .x(xb), .y(yb), .colour_out(cb), .plot(plotb), .busy(busyb), .done(doneb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input int s, input string tag, input int ep, input int eb, input int ed);
        if (s == 0) begin
            check({tag, "_a_plot"}, 32'(plota), 32'(ep));
            check({tag, "_a_x"}, 32'(xa), 32'(ex[0]));
            check({tag, "_a_y"}, 32'(ya), 32'(ey[0]));
            check({tag, "_a_col"}, 32'(ca), 32'(ec[0]));
            check({tag, "_a_busy"}, 32'(busya), 32'(eb));
            check({tag, "_a_done"}, 32'(donea), 32'(ed));
        end else begin
            check({tag, "_b_plot"}, 32'(plotb), 32'(ep));
            check({tag, "_b_x"}, 32'(xb), 32'(ex[1]));
            check({tag, "_b_y"}, 32'(yb), 32'(ey[1]));
            check({tag, "_b_col"}, 32'(cb), 32'(ec[1]));
            check({tag, "_b_busy"}, 32'(busyb), 32'(eb));
            check({tag, "_b_done"}, 32'(doneb), 32'(ed));
        end
    endtask

    // Arrow geometry: pixel i of the draw sequence for direction d.
    task automatic model_pixel(input int s, input int d, input int i, output int px, output int py);
        int ox, oy, dx, dy, j, tx, ty, off;
        ox = (s == 0) ? OXA : OXB;
        oy = (s == 0) ? OYA : OYB;
        dx = (d == 3) ? 1 : (d == 2) ? -1 : 0;
        dy = (d == 1) ? 1 : (d == 0) ? -1 : 0;
        if (i < SHAFT) begin
            px = ox + i * dx;
            py = oy + i * dy;
        end else begin
            j   = (i - SHAFT) / 2 + 1;
            tx  = ox + (SHAFT - 1) * dx - j * dx;
            ty  = oy + (SHAFT - 1) * dy - j * dy;
            off = ((i - SHAFT) % 2 == 1) ? j : -j;
            if (dx == 0) begin
                px = tx + off;
                py = ty;
            end else begin
                px = tx;
                py = ty + off;
            end
        end
    endtask

    task automatic model_reset();
        ex[0] = OXA; ey[0] = OYA; ec[0] = 0;
        ex[1] = OXB; ey[1] = OYB; ec[1] = 0;
    endtask

    task automatic draw(input int s, input int d, input int c, input bit poke, input bit abort);
        int sd, h, eb, done_e, idx, col, px, py, nplots, ep;
        sd = (s == 0) ? SD_A : SD_B;
        h  = (s == 0) ? H_A : H_B;
        eb = (P + h) * sd + 1;
        done_e = eb + (ERASE ? P * sd : 0);
        nplots = 0;
        dir = 2'(d);
        colour = 3'(c);
        if (s == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        check_all(s, "accept", 0, 1, 0);
        for (int e = 1; e <= done_e + 2; e++) begin
            if (poke && (e == 2 || e == done_e + 1)) begin
                if (s == 0) start_a = 1'b1; else start_b = 1'b1;
            end
            @(posedge clk); #1;
            start_a = 1'b0; start_b = 1'b0;
            idx = -1;
            col = c;
            if (e % sd == 0 && e / sd >= 1 && e / sd <= P) begin
                idx = e / sd - 1;
            end else if (ERASE && e > eb && (e - eb) % sd == 0 && (e - eb) / sd <= P) begin
                idx = (e - eb) / sd - 1;
                col = 0;
            end
            ep = 0;
            if (idx >= 0) begin
                model_pixel(s, d, idx, px, py);
                if (px >= 0 && px <= XMAX && py >= 0 && py <= YMAX) begin
                    ep = 1;
                    ex[s] = px; ey[s] = py; ec[s] = col;
                    nplots++;
                end
            end
            check_all(s, "step", ep, (e <= done_e) ? 1 : 0, (e == done_e) ? 1 : 0);
            if (abort && nplots == 3) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                model_reset();
                check_all(s, "abort", 0, 0, 0);
                for (int n = 0; n < done_e + 2; n++) begin
                    @(posedge clk); #1;
                    check_all(s, "post_abort", 0, 0, 0);
                end
                return;
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all(0, "reset", 0, 0, 0);
        check_all(1, "reset", 0, 0, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check_all(0, "idle", 0, 0, 0);

        draw(0, 0, 5, 1'b0, 1'b0);
        draw(1, 3, 6, 1'b0, 1'b0);
        draw(1, 0, 2, 1'b0, 1'b0);
        draw(0, 2, 3, 1'b1, 1'b0);
        draw(0, 0, 7, 1'b0, 1'b1);
        draw(1, 2, 4, 1'b1, 1'b0);

        for (int r = 0; r < 20; r++) begin
            int s, d, c, gap;
            bit pk;
            s   = int'($urandom_range(0, 1));
            d   = int'($urandom_range(0, 3));
            c   = int'($urandom_range(0, 7));
            pk  = 1'($urandom_range(0, 1));
            gap = int'($urandom_range(0, 3));
            repeat (gap) @(posedge clk);
            #1;
            draw(s, d, c, pk, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
